folded_iir_n: RTL and testbench



---
 rtl/folded_iir_pkg.sv | 31 +++
 rtl/folded_iir_hist.sv | 67 ++++++
 rtl/folded_iir_n.sv | 147 ++++++++++++++
 tb/tb_folded_iir_n.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/folded_iir_pkg.sv
// folded_iir_pkg: shared types and arithmetic helpers for the folded IIR filter.
// Saturating arithmetic is selected in the datapath with `ifdef FOLDED_IIR_SAT_EN.
package folded_iir_pkg;

  // Sequencer states: IDLE waits for a sample, MAC walks the taps.
  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  // Clamp a wide signed value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

  // Drop the fractional bits of a product; the low W bits of the result are
  // the product slice [FRAC+W-1:FRAC], the upper bits tell whether it overflowed.
  function automatic logic signed [63:0] prod_slice(input logic signed [63:0] p, input int frac);
    return p >>> frac;
  endfunction

endpackage

// File: rtl/folded_iir_hist.sv
// folded_iir_hist: MAX_LAG-deep ring buffer of past outputs with a write
// pointer, one lag-addressed asynchronous read port and a synchronous clear.
module folded_iir_hist
  import folded_iir_pkg::*;
#(
  parameter int W       = 16,
  parameter int MAX_LAG = 8,
  parameter int LAGW    = $clog2(MAX_LAG) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [LAGW-1:0] rd_lag,
  output logic [W-1:0]    rd_data,
  input  logic            we,
  input  logic [W-1:0]    wr_data
);

  localparam int AW = $clog2(MAX_LAG);

  logic [W-1:0]  mem_q [MAX_LAG];
  logic [W-1:0]  mem_d [MAX_LAG];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] wp_d;
  logic [AW-1:0] rd_addr;
  logic          rd_en;

  // Lag d reads the entry written d samples ago; d == MAX_LAG lands on wp,
  // the oldest entry, which is only overwritten at the end of this sample.
  always_comb begin
    rd_addr = wp_q - rd_lag[AW-1:0];
    rd_en   = (rd_lag != '0) && (rd_lag <= LAGW'(MAX_LAG));
    rd_data = rd_en ? mem_q[rd_addr] : '0;
  end

  // Per-entry next value: clear wins, otherwise the slot under wp takes the write.
  for (genvar gi = 0; gi < MAX_LAG; gi++) begin : g_entry
    assign mem_d[gi] = clr ? '0 :
                       (we && (wp_q == AW'(gi))) ? wr_data : mem_q[gi];
  end

  // Write pointer advances once per completed sample and wraps naturally.
  always_comb begin
    wp_d = wp_q;
    if (clr) begin
      wp_d = '0;
    end else if (we) begin
      wp_d = wp_q + 1'b1;
    end
  end

  // History and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAG; i++) begin
        mem_q[i] <= '0;
      end
      wp_q <= '0;
    end else begin
      for (int i = 0; i < MAX_LAG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q <= wp_d;
    end
  end

endmodule

// File: rtl/folded_iir_n.sv
// folded_iir_n: TAPS-folded IIR, Y[n] = X[n] + sum_k c_k * Y[n - d_k], using
// one multiplier and one adder over TAPS MAC cycles per sample.
// Define FOLDED_IIR_SAT_EN for saturating product slice and accumulation;
// otherwise the slice truncates and adds wrap modulo 2^W.
module folded_iir_n
  import folded_iir_pkg::*;
#(
  parameter int W       = 16,
  parameter int TAPS    = 2,
  parameter int MAX_LAG = 8,
  parameter int FRAC    = 0,
  parameter int LAGW    = $clog2(MAX_LAG) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           x_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAPS*W-1:0]      coef,
  input  logic [TAPS*LAGW-1:0]   lag,
  input  logic                   hist_clr,
  output logic [W-1:0]           y_out,
  output logic                   out_valid
);

  localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [W-1:0]    acc_q, acc_d;
  logic [W-1:0]           y_q, y_d;
  logic                   out_valid_q, out_valid_d;
  logic [TAPS*W-1:0]      coef_q, coef_d;
  logic [TAPS*LAGW-1:0]   lag_q, lag_d;

  logic signed [W-1:0]    coef_arr [TAPS];
  logic [LAGW-1:0]        lag_arr  [TAPS];
  logic signed [W-1:0]    tap_coef;
  logic [LAGW-1:0]        tap_lag;
  logic [W-1:0]           hist_rd;
  logic                   hist_we;
  logic signed [2*W-1:0]  prod;
  logic signed [W-1:0]    term;
  logic signed [W-1:0]    mac_sum;

  // Unpack the captured coefficient and lag vectors per tap.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    assign coef_arr[gi] = coef_q[gi*W +: W];
    assign lag_arr[gi]  = lag_q[gi*LAGW +: LAGW];
  end

  assign tap_coef  = coef_arr[k_q];
  assign tap_lag   = lag_arr[k_q];
  assign in_ready  = (state_q == IDLE);
  assign y_out     = y_q;
  assign out_valid = out_valid_q;

  folded_iir_hist #(
    .W       (W),
    .MAX_LAG (MAX_LAG),
    .LAGW    (LAGW)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clr     (hist_clr),
    .rd_lag  (tap_lag),
    .rd_data (hist_rd),
    .we      (hist_we),
    .wr_data (mac_sum)
  );

  // Shared multiply-accumulate: scale the product, then add to the running sum.
  always_comb begin
    prod = tap_coef * $signed(hist_rd);
`ifdef FOLDED_IIR_SAT_EN
    term    = W'(sat_w(prod_slice(64'(prod), FRAC), W));
    mac_sum = W'(sat_w(64'(acc_q) + 64'(term), W));
`else
    term    = W'(prod_slice(64'(prod), FRAC));
    mac_sum = acc_q + term;
`endif
  end

  // Sequencer: accept a sample, step through the taps, publish on the last one.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    coef_d      = coef_q;
    lag_d       = lag_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    hist_we     = 1'b0;
    if (hist_clr) begin
      // Abort any sample in flight; y_out keeps its last value.
      state_d = IDLE;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = $signed(x_in);
            coef_d  = coef;
            lag_d   = lag;
            k_d     = '0;
            state_d = MAC;
          end
        end
        MAC: begin
          acc_d = mac_sum;
          if (k_q == KW'(TAPS - 1)) begin
            hist_we     = 1'b1;
            y_d         = mac_sum;
            out_valid_d = 1'b1;
            k_d         = '0;
            state_d     = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      coef_q      <= '0;
      lag_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      coef_q      <= coef_d;
      lag_q       <= lag_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_folded_iir_n.sv
// tb_folded_iir_n: self-checking bench for folded_iir_n (W=16, TAPS=2,
// MAX_LAG=8). A second instance with FRAC=14 covers fixed-point scaling.
// Expected outputs come from a sample-level model that keeps every output
// since the last clear and evaluates the filter equation directly.
module tb_folded_iir_n;

  logic        clk;
  logic        rst;
  logic [15:0] x_in;
  logic        in_valid;
  logic        in_valid_fx;
  logic        in_ready;
  logic        in_ready_fx;
  logic [31:0] coef;
  logic [7:0]  lag;
  logic        hist_clr;
  logic [15:0] y_out;
  logic [15:0] y_out_fx;
  logic        out_valid;
  logic        out_valid_fx;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] IMP_COEF = {16'd1, 16'd2};
  localparam logic [7:0]  IMP_LAG  = {4'd5, 4'd3};
  int imp_exp [9] = '{1, 0, 0, 2, 0, 1, 4, 0, 4};

  longint yq [$];

  folded_iir_n dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef      (coef),
    .lag       (lag),
    .hist_clr  (hist_clr),
    .y_out     (y_out),
    .out_valid (out_valid)
  );

  folded_iir_n #(.FRAC(14)) dut_fx (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .in_valid  (in_valid_fx),
    .in_ready  (in_ready_fx),
    .coef      (coef),
    .lag       (lag),
    .hist_clr  (hist_clr),
    .y_out     (y_out_fx),
    .out_valid (out_valid_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reduce a value to the 16-bit output range (wrap or clamp).
  function automatic longint fit(input longint v);
`ifdef FOLDED_IIR_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic [15:0] t;
    t = v[15:0];
    return longint'($signed(t));
`endif
  endfunction

  // Filter equation for one new sample; appends the result to the history.
  function automatic logic [15:0] model_y(input logic [15:0] xv, input logic [31:0] cv,
                                          input logic [7:0] lv, input int frac);
    longint acc;
    longint c;
    longint past;
    longint term;
    int d;
    int n;
    acc = longint'($signed(xv));
    for (int k = 0; k < 2; k++) begin
      c = longint'($signed(cv[k*16 +: 16]));
      d = int'(lv[k*4 +: 4]);
      n = yq.size();
      past = 0;
      if (d >= 1 && d <= 8) begin
        if (n - d >= 0) past = yq[n - d];
        term = fit((c * past) >>> frac);
        acc  = fit(acc + term);
      end
    end
    yq.push_back(acc);
    return acc[15:0];
  endfunction

  task automatic do_clear;
    @(negedge clk);
    hist_clr = 1'b1;
    @(negedge clk);
    hist_clr = 1'b0;
    yq.delete();
  endtask

  // Present one sample to an idle instance, scramble coef/lag after acceptance,
  // and wait (bounded) for its result. lat counts cycles from accept to out_valid.
  task automatic send(input bit fx, input logic [15:0] xv, input logic [31:0] cv,
                      input logic [7:0] lv, output logic [15:0] y, output int lat);
    @(negedge clk);
    x_in = xv;
    coef = cv;
    lag  = lv;
    if (fx) in_valid_fx = 1'b1;
    else    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    in_valid_fx = 1'b0;
    coef = $urandom;
    lag  = 8'($urandom);
    x_in = 16'($urandom);
    lat  = 1;
    y    = 'x;
    while (lat <= 20) begin
      if ((fx ? out_valid_fx : out_valid) === 1'b1) begin
        y = fx ? y_out_fx : y_out;
        break;
      end
      @(negedge clk);
      lat++;
    end
    if (lat > 20) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (y_out !== 16'd0) begin
      n_fail++; $display("FAIL reset y_out: got %0d want 0", y_out);
    end
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid);
    end
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset released: y_out=%0d out_valid=%b in_ready=%b", y_out, out_valid, in_ready);
  endtask

  task automatic run_impulse(input string tag);
    logic [15:0] y;
    int lat;
    for (int i = 0; i < 9; i++) begin
      send(1'b0, (i == 0) ? 16'd1 : 16'd0, IMP_COEF, IMP_LAG, y, lat);
      $display("%s n=%0d y=%0d lat=%0d", tag, i, $signed(y), lat);
      n_assert++;
      if (y !== 16'(imp_exp[i])) begin
        n_fail++; $display("FAIL %s y[%0d]: got %0d want %0d", tag, i, $signed(y), imp_exp[i]);
      end
      n_assert++;
      if (lat != 3) begin
        n_fail++; $display("FAIL %s latency[%0d]: got %0d want 3", tag, i, lat);
      end
    end
  endtask

  task automatic test_impulse;
    do_clear;
    run_impulse("impulse");
  endtask

  task automatic test_random;
    logic [15:0] y;
    logic [15:0] xv;
    logic [15:0] exp_y;
    logic [31:0] cv;
    logic [7:0]  lv;
    int lat;
    do_clear;
    for (int i = 0; i < 24; i++) begin
      xv = 16'($urandom);
      cv = $urandom;
      lv = 8'($urandom);
      if (i % 4 == 0) cv = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
      exp_y = model_y(xv, cv, lv, 0);
      send(1'b0, xv, cv, lv, y, lat);
      $display("random n=%0d x=%0d coef=%h lag=%h y=%0d", i, $signed(xv), cv, lv, $signed(y));
      n_assert++;
      if (y !== exp_y) begin
        n_fail++; $display("FAIL random y[%0d]: got %0d want %0d", i, $signed(y), $signed(exp_y));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] xv;
    logic [15:0] exp_y;
    logic [31:0] cv;
    logic [7:0]  lv;
    logic [15:0] expq [$];
    logic        exp_rdy;
    logic        exp_ov;
    bit          acc_now;
    do_clear;
    cv = $urandom;
    lv = 8'($urandom);
    @(negedge clk);
    xv = 16'($urandom);
    x_in = xv; coef = cv; lag = lv; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 13) in_valid = 1'b0;
      exp_rdy = (i % 3 == 0);
      exp_ov  = (i % 3 == 0) && (i > 0);
      n_assert++;
      if (in_ready !== exp_rdy) begin
        n_fail++; $display("FAIL b2b in_ready@%0d: got %b want %b", i, in_ready, exp_rdy);
      end
      n_assert++;
      if (out_valid !== exp_ov) begin
        n_fail++; $display("FAIL b2b out_valid@%0d: got %b want %b", i, out_valid, exp_ov);
      end
      if (out_valid === 1'b1 && expq.size() > 0) begin
        exp_y = expq.pop_front();
        $display("b2b cycle=%0d y=%0d", i, $signed(y_out));
        n_assert++;
        if (y_out !== exp_y) begin
          n_fail++; $display("FAIL b2b y@%0d: got %0d want %0d", i, $signed(y_out), $signed(exp_y));
        end
      end
      acc_now = (in_ready === 1'b1) && (in_valid === 1'b1);
      if (acc_now) expq.push_back(model_y(xv, cv, lv, 0));
      @(negedge clk);
      if (acc_now) begin
        xv = 16'($urandom);
        x_in = xv;
      end
    end
    n_assert++;
    if (expq.size() != 0) begin
      n_fail++; $display("FAIL b2b drained: got %0d left want 0", expq.size());
    end
  endtask

  task automatic test_sat;
    logic [15:0] y;
    logic [15:0] exp2;
    int lat;
`ifdef FOLDED_IIR_SAT_EN
    exp2 = 16'd32767;
`else
    exp2 = 16'hEA60;
`endif
    do_clear;
    send(1'b0, 16'd30000, {16'd0, 16'd1}, {4'd0, 4'd1}, y, lat);
    $display("sat n=0 y=%0d", $signed(y));
    n_assert++;
    if (y !== 16'd30000) begin
      n_fail++; $display("FAIL sat y0: got %0d want 30000", $signed(y));
    end
    send(1'b0, 16'd30000, {16'd0, 16'd1}, {4'd0, 4'd1}, y, lat);
    $display("sat n=1 y=%0d", $signed(y));
    n_assert++;
    if (y !== exp2) begin
      n_fail++; $display("FAIL sat y1: got %0d want %0d", $signed(y), $signed(exp2));
    end
  endtask

  task automatic test_fixed_point;
    logic [15:0] y;
    int lat;
    int fx_exp [4] = '{1000, 500, 250, 125};
    do_clear;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, (i == 0) ? 16'd1000 : 16'd0, {16'd0, 16'd8192}, {4'd0, 4'd1}, y, lat);
      $display("fixed n=%0d y=%0d", i, $signed(y));
      n_assert++;
      if (y !== 16'(fx_exp[i])) begin
        n_fail++; $display("FAIL fixed y[%0d]: got %0d want %0d", i, $signed(y), fx_exp[i]);
      end
    end
  endtask

  task automatic test_disabled_lag;
    logic [15:0] y;
    logic [15:0] exp_y;
    int lat;
    do_clear;
    for (int i = 0; i < 9; i++) begin
      exp_y = (i == 0 || i == 8) ? 16'd7 : 16'd0;
      send(1'b0, (i == 0) ? 16'd7 : 16'd0, {16'd1, 16'd5}, {4'd8, 4'd0}, y, lat);
      $display("lagedge n=%0d y=%0d", i, $signed(y));
      n_assert++;
      if (y !== exp_y) begin
        n_fail++; $display("FAIL lagedge y[%0d]: got %0d want %0d", i, $signed(y), $signed(exp_y));
      end
    end
  endtask

  task automatic test_abort(input bit use_rst);
    logic [15:0] y;
    int lat;
    int pulses;
    string tag;
    tag = use_rst ? "abort_rst" : "abort_clr";
    do_clear;
    for (int i = 0; i < 5; i++) send(1'b0, 16'($urandom_range(1, 50)), IMP_COEF, IMP_LAG, y, lat);
    @(negedge clk);
    x_in = 16'd1; coef = IMP_COEF; lag = IMP_LAG; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_assert++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: got in_ready=%b want 0", tag, in_ready);
    end
    if (use_rst) rst = 1'b1;
    else         hist_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hist_clr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    $display("%s aborted: out_valid pulses=%0d", tag, pulses);
    n_assert++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL %s pulses: got %0d want 0", tag, pulses);
    end
    yq.delete();
    run_impulse(tag);
  endtask

  initial begin
    rst = 1'b1; x_in = '0; in_valid = 1'b0; in_valid_fx = 1'b0;
    coef = '0; lag = '0; hist_clr = 1'b0;
    test_reset;
    test_impulse;
    test_random;
    test_back_to_back;
    test_sat;
    test_fixed_point;
    test_disabled_lag;
    test_abort(1'b1);
    test_abort(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
